// File: rtl/latch_bank_wr_sched.sv
// latch_bank_wr_sched: round-robin write scheduler for a shared latch bank.
// Sequences setup -> enable pulse -> hold per write; bank clear via lat_rst_n.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req/req_addr/data   per-requester write request, address, data
//   ack, err            completion pulse per requester, bad-address flag
//   clr_req, clr_done   bank clear request and completion pulse
//   lat_d, lat_en       shared latch data bus, one-hot word enable
//   lat_rst_n, busy     bank-wide latch reset, sequencer active
module latch_bank_wr_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  input  logic              clr_req,
  output logic              clr_done,
  output logic [DW-1:0]     lat_d,
  output logic [DEPTH-1:0]  lat_en,
  output logic              lat_rst_n,
  output logic              busy
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int M1 = (SETUP_CYC > PULSE_CYC)
                    ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] C_SET = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_PUL = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] C_HLD = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CLEAR
  } state_t;

  state_t          st_q;
  state_t          st_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [RW-1:0]   rr_q;
  logic [RW-1:0]   g_q;
  logic [RW-1:0]   g_d;
  logic [AW-1:0]   addr_q;
  logic            gnt_vld;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;
  logic            addr_ok;
  logic [DEPTH-1:0] dec;
  logic [NREQ-1:0] g_oh;
  logic            last_d;
  int              idx;

  // First requesting index at or after the rr pointer.
  always_comb begin
    gnt_vld = 1'b0;
    g_d     = rr_q;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_q) + i) % NREQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        g_d     = RW'(idx);
      end
    end
    gnt_addr = req_addr[int'(g_d)*AW +: AW];
    gnt_data = req_data[int'(g_d)*DW +: DW];
  end

  always_comb begin
    addr_ok = int'(addr_q) < DEPTH;
    for (int k = 0; k < DEPTH; k++)
      dec[k] = addr_ok && (int'(addr_q) == k);
    for (int n = 0; n < NREQ; n++)
      g_oh[n] = (int'(g_q) == n);
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (clr_req) begin
          st_d  = CLEAR;
          cnt_d = C_PUL;
        end else if (gnt_vld) begin
          st_d  = SETUP;
          cnt_d = C_SET;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          st_d  = PULSE;
          cnt_d = C_PUL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          st_d  = HOLD;
          cnt_d = C_HLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD, CLEAR: begin
        if (cnt_q == '0) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Next cycle is the final one of its state.
  assign last_d = (cnt_d == '0);

  // Outputs are registered from the next state so each
  // pulse lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      rr_q      <= '0;
      g_q       <= '0;
      addr_q    <= '0;
      ack       <= '0;
      err       <= 1'b0;
      clr_done  <= 1'b0;
      lat_d     <= '0;
      lat_en    <= '0;
      lat_rst_n <= 1'b0;
      busy      <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (st_q == IDLE && !clr_req && gnt_vld) begin
        g_q    <= g_d;
        addr_q <= gnt_addr;
        lat_d  <= gnt_data;
      end
      if (st_q == HOLD && cnt_q == '0)
        rr_q <= (g_q == RW'(NREQ - 1))
              ? '0 : g_q + RW'(1);
      lat_en    <= (st_d == PULSE) ? dec : '0;
      ack       <= (st_d == HOLD && last_d)
                 ? g_oh : '0;
      err       <= st_d == HOLD && last_d && !addr_ok;
      clr_done  <= st_d == CLEAR && last_d;
      lat_rst_n <= st_d != CLEAR;
      busy      <= st_d != IDLE;
    end
  end

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// tb_latch_bank_wr_sched: directed + random checks of the latch write scheduler.
// Reference: latch bank contents, round-robin order and sequence timing.
module tb_latch_bank_wr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        err;
  logic        clr_req;
  logic        clr_done;
  logic [7:0]  lat_d;
  logic [7:0]  lat_en;
  logic        lat_rst_n;
  logic        busy;

  logic        rst6_n;
  logic [3:0]  req6;
  logic [11:0] req_addr6;
  logic [31:0] req_data6;
  logic [3:0]  ack6;
  logic        err6;
  logic        clr_done6;
  logic [7:0]  lat_d6;
  logic [5:0]  lat_en6;
  logic        lat_rst_n6;
  logic        busy6;

  int checks = 0;
  int errors = 0;

  int         m_rr;
  bit         pend [4];
  logic [2:0] q_addr [4];
  logic [7:0] q_data [4];
  logic [7:0] m_mem [8];
  logic [7:0] latm [8];
  logic [7:0] prev_d;
  bit         mon_on = 0;

  latch_bank_wr_sched u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .err(err), .clr_req(clr_req),
    .clr_done(clr_done), .lat_d(lat_d),
    .lat_en(lat_en), .lat_rst_n(lat_rst_n),
    .busy(busy)
  );

  latch_bank_wr_sched #(.DEPTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst6_n), .req(req6),
    .req_addr(req_addr6), .req_data(req_data6),
    .ack(ack6), .err(err6), .clr_req(1'b0),
    .clr_done(clr_done6), .lat_d(lat_d6),
    .lat_en(lat_en6), .lat_rst_n(lat_rst_n6),
    .busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural latch bank plus bus-protocol rules, once per cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      assert (lat_en == '0 ||
              (lat_rst_n && $onehot(lat_en) &&
               lat_d == prev_d))
      else begin
        errors++;
        $error("FAIL latch_protocol: en=%b rst_n=%b d=%h prev_d=%h",
               lat_en, lat_rst_n, lat_d, prev_d);
      end
      if (!lat_rst_n) begin
        for (int k = 0; k < 8; k++) latm[k] = '0;
      end else begin
        for (int k = 0; k < 8; k++)
          if (lat_en[k]) latm[k] = lat_d;
      end
    end
    prev_d = lat_d;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rq(input int i,
                        input logic [2:0] a,
                        input logic [7:0] d);
    req_addr[i*3 +: 3] = a;
    req_data[i*8 +: 8] = d;
    q_addr[i] = a;
    q_data[i] = d;
  endtask

  task automatic clr_model();
    for (int k = 0; k < 8; k++) m_mem[k] = '0;
  endtask

  function automatic int pick();
    for (int i = 0; i < 4; i++) begin
      int j = (m_rr + i) % 4;
      if (pend[j]) return j;
    end
    return 0;
  endfunction

  task automatic cmp_mem(input string tag);
    logic [63:0] o;
    logic [63:0] e;
    for (int k = 0; k < 8; k++) begin
      o[k*8 +: 8] = latm[k];
      e[k*8 +: 8] = m_mem[k];
    end
    chk(tag, o, e);
  endtask

  task automatic wait_ack(output logic [3:0] a,
                          output logic e,
                          output int cyc);
    a = '0;
    e = 1'b0;
    cyc = 0;
    while (a == '0 && cyc < 40) begin
      step();
      cyc++;
      a = ack;
      e = err;
    end
    chk("ack_seen", 64'(a != '0), 64'(1));
  endtask

  task automatic wait_clr(output int cyc);
    logic d;
    d = 1'b0;
    cyc = 0;
    while (!d && cyc < 40) begin
      step();
      cyc++;
      d = clr_done;
    end
    chk("clr_done_seen", 64'(d), 64'(1));
    chk("clr_rst_low", 64'(lat_rst_n), 64'(0));
  endtask

  // Serve a full set of requests; optionally keep them all held.
  task automatic rr_run(input bit drop_each,
                        input int n,
                        input string tag);
    logic [3:0] a;
    logic e;
    int cyc;
    int ex;
    for (int i = 0; i < 4; i++) begin
      set_rq(i, 3'($urandom_range(0, 7)),
             8'($urandom));
      pend[i] = 1;
    end
    req = 4'b1111;
    for (int t = 0; t < n; t++) begin
      ex = pick();
      wait_ack(a, e, cyc);
      chk(tag, 64'(a), 64'(1) << ex);
      chk({tag, "_err"}, 64'(e), 64'(0));
      m_mem[q_addr[ex]] = q_data[ex];
      m_rr = (ex + 1) % 4;
      if (drop_each) begin
        req[ex] = 1'b0;
        pend[ex] = 0;
      end
    end
    req = '0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
    step();
    step();
    cmp_mem({tag, "_mem"});
  endtask

  initial begin
    logic [3:0] a;
    logic e;
    logic [3:0] acc;
    logic [2:0] ra;
    logic [7:0] rd;
    int cyc;
    int ex;
    bit any;
    bit do_clr;

    rst_n = 1'b0;
    rst6_n = 1'b0;
    req = 4'b1111;
    req_addr = '0;
    req_data = '0;
    clr_req = 1'b0;
    req6 = '0;
    req_addr6 = '0;
    req_data6 = '0;
    m_rr = 0;
    clr_model();
    for (int i = 0; i < 4; i++) pend[i] = 0;

    // Reset with all requests raised
    repeat (3) step();
    mon_on = 1;
    chk("rst_lat_rst_n", 64'(lat_rst_n), 64'(0));
    chk("rst_lat_en", 64'(lat_en), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    req = '0;
    rst_n = 1'b1;
    rst6_n = 1'b1;
    step();
    chk("rel_lat_rst_n", 64'(lat_rst_n), 64'(1));
    chk("rel_busy", 64'(busy), 64'(0));

    // Single write, requester 2
    set_rq(2, 3'd5, 8'hA5);
    req[2] = 1'b1;
    step();
    chk("sw_busy", 64'(busy), 64'(1));
    chk("sw_lat_d", 64'(lat_d), 64'hA5);
    chk("sw_setup_en", 64'(lat_en), 64'(0));
    req_addr[6 +: 3] = 3'd1;
    req_data[16 +: 8] = 8'h3C;
    step();
    chk("sw_pulse1", 64'(lat_en), 64'h20);
    chk("sw_lat_d_held", 64'(lat_d), 64'hA5);
    step();
    chk("sw_pulse2", 64'(lat_en), 64'h20);
    chk("sw_pre_ack", 64'(ack), 64'(0));
    step();
    chk("sw_hold_en", 64'(lat_en), 64'(0));
    chk("sw_ack", 64'(ack), 64'h4);
    chk("sw_err", 64'(err), 64'(0));
    req[2] = 1'b0;
    m_mem[5] = 8'hA5;
    step();
    chk("sw_ack_pulse", 64'(ack), 64'(0));
    chk("sw_idle", 64'(busy), 64'(0));
    step();
    cmp_mem("sw_mem");

    // Reset clears the bank and the rr pointer
    rst_n = 1'b0;
    step();
    chk("rst2_lat_rst_n", 64'(lat_rst_n), 64'(0));
    rst_n = 1'b1;
    clr_model();
    m_rr = 0;
    step();
    step();
    cmp_mem("rst2_mem");

    // Round-robin: drop after own ack, then held throughout
    rr_run(1'b1, 4, "rr_drop");
    rr_run(1'b0, 5, "rr_held");

    // Clear wins over a simultaneous write request
    ra = 3'($urandom_range(0, 7));
    rd = 8'($urandom);
    set_rq(0, ra, rd);
    clr_req = 1'b1;
    req[0] = 1'b1;
    step();
    chk("cp_rst1", 64'(lat_rst_n), 64'(0));
    chk("cp_busy", 64'(busy), 64'(1));
    chk("cp_done1", 64'(clr_done), 64'(0));
    step();
    chk("cp_rst2", 64'(lat_rst_n), 64'(0));
    chk("cp_done2", 64'(clr_done), 64'(1));
    clr_req = 1'b0;
    clr_model();
    step();
    chk("cp_rst_up", 64'(lat_rst_n), 64'(1));
    chk("cp_done_pulse", 64'(clr_done), 64'(0));
    ex = (m_rr == 0) ? 0 : 0;
    wait_ack(a, e, cyc);
    chk("cp_ack", 64'(a), 64'h1);
    req[0] = 1'b0;
    m_mem[ra] = rd;
    m_rr = 1;
    step();
    cmp_mem("cp_mem");

    // Clear raised during a write's enable pulse
    set_rq(1, 3'($urandom_range(0, 7)), 8'($urandom));
    req[1] = 1'b1;
    step();
    step();
    clr_req = 1'b1;
    wait_ack(a, e, cyc);
    chk("cw_ack", 64'(a), 64'h2);
    req[1] = 1'b0;
    m_rr = 2;
    wait_clr(cyc);
    chk("cw_gap", 64'(cyc), 64'(3));
    clr_req = 1'b0;
    clr_model();
    step();
    cmp_mem("cw_mem");

    // Bad address on the 6-word bank
    req_addr6[0 +: 3] = 3'd7;
    req_data6[0 +: 8] = 8'h77;
    req6[0] = 1'b1;
    step();
    chk("ba_busy", 64'(busy6), 64'(1));
    step();
    chk("ba_en1", 64'(lat_en6), 64'(0));
    step();
    chk("ba_en2", 64'(lat_en6), 64'(0));
    step();
    chk("ba_ack", 64'(ack6), 64'h1);
    chk("ba_err", 64'(err6), 64'(1));
    req6 = '0;
    step();
    chk("ba_err_pulse", 64'(err6), 64'(0));

    // Reset mid-pulse aborts the write
    req_addr6[3 +: 3] = 3'd2;
    req_data6[8 +: 8] = 8'h5A;
    req6[1] = 1'b1;
    step();
    step();
    chk("ab_en", 64'(lat_en6), 64'h04);
    rst6_n = 1'b0;
    req6 = '0;
    step();
    chk("ab_en_off", 64'(lat_en6), 64'(0));
    chk("ab_ack", 64'(ack6), 64'(0));
    chk("ab_busy", 64'(busy6), 64'(0));
    chk("ab_lat_rst", 64'(lat_rst_n6), 64'(0));
    rst6_n = 1'b1;
    acc = '0;
    repeat (8) begin
      step();
      acc = acc | ack6;
    end
    chk("ab_no_ack", 64'(acc), 64'(0));

    // Random traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      any = 0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_rq(i, 3'($urandom_range(0, 7)),
                 8'($urandom));
          pend[i] = 1;
          req[i] = 1'b1;
        end
        if (pend[i]) any = 1;
      end
      if (!any) begin
        ex = int'($urandom_range(0, 3));
        set_rq(ex, 3'($urandom_range(0, 7)),
               8'($urandom));
        pend[ex] = 1;
        req[ex] = 1'b1;
      end
      do_clr = ($urandom_range(0, 5) == 0);
      if (do_clr) begin
        clr_req = 1'b1;
        wait_clr(cyc);
        chk("rnd_clr_gap", 64'(cyc),
            64'((it == 0) ? 2 : 3));
        clr_req = 1'b0;
        clr_model();
      end
      ex = pick();
      wait_ack(a, e, cyc);
      chk("rnd_ack", 64'(a), 64'(1) << ex);
      chk("rnd_err", 64'(e), 64'(0));
      chk("rnd_gap", 64'(cyc),
          64'((it == 0 && !do_clr) ? 4 : 5));
      m_mem[q_addr[ex]] = q_data[ex];
      m_rr = (ex + 1) % 4;
      req[ex] = 1'b0;
      pend[ex] = 0;
      cmp_mem("rnd_mem");
    end
    req = '0;
    step();
    step();
    cmp_mem("rnd_final_mem");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
